// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: single bus-cycle engine for the external RTC's
// multiplexed address/data bus. Serves keyboard writes and periodic refresh
// sweeps, alternating between them on contention, and keeps a shadow copy
// of the swept registers that only ever shows complete sweeps.
// Optional feature: define RTC_SEQ_VERIFY_EN to read back every write and
// flag mismatches on wr_err.
module rtc_bus_sequencer #(
   parameter int         PH_CYC   = 4,
   parameter logic [7:0] REF_BASE = 8'h21,
   parameter int         REF_CNT  = 9
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   input  logic       ref_tick,
   output logic       busy,
   input  logic [3:0] sh_idx,
   output logic [7:0] sh_val,
   output logic       sh_upd,
   output logic       rtc_cs_n,
   output logic       rtc_rd_n,
   output logic       rtc_wr_n,
   output logic       rtc_ad_n,
   output logic [7:0] rtc_ad_o,
   output logic       rtc_ad_oe,
   input  logic [7:0] rtc_ad_i
`ifdef RTC_SEQ_VERIFY_EN
   ,
   output logic       wr_err
`endif
);

   typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, DONE} state_t;

   localparam logic [7:0] PH_LAST  = 8'(PH_CYC - 1);
   localparam logic [3:0] IDX_LAST = 4'(REF_CNT - 1);

   state_t     state;
   logic [7:0] ph_cnt;
   logic       cyc_wr;      // current bus cycle is a write
   logic       cyc_ref;     // current bus cycle is a sweep read
   logic [7:0] cyc_addr;
   logic [7:0] cyc_data;
   logic       ref_pend;
   logic       sweeping;
   logic [3:0] sw_idx;
   logic       turn_wr;     // on contention, the write goes next
   logic [7:0] stage  [16];
   logic [7:0] shadow [16];
`ifdef RTC_SEQ_VERIFY_EN
   logic       vfy;         // current read is the read-back of a write
   logic [7:0] rd_data;
`endif

   logic       ph_done;
   logic [7:0] sweep_addr;
   logic       want_rd;

   assign ph_done    = (ph_cnt == 8'd0);
   assign sweep_addr = REF_BASE + {4'd0, sw_idx};
   assign want_rd    = sweeping | ref_pend;
   assign busy       = (state != IDLE) | sweeping;
   assign sh_val     = (int'(sh_idx) < REF_CNT) ? shadow[sh_idx] : 8'h00;

   // Bus cycle FSM with arbitration, sweep bookkeeping and registered strobes
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         ph_cnt    <= 8'd0;
         cyc_wr    <= 1'b0;
         cyc_ref   <= 1'b0;
         cyc_addr  <= 8'h00;
         cyc_data  <= 8'h00;
         ref_pend  <= 1'b0;
         sweeping  <= 1'b0;
         sw_idx    <= 4'd0;
         turn_wr   <= 1'b1;
         wr_ack    <= 1'b0;
         sh_upd    <= 1'b0;
         rtc_cs_n  <= 1'b1;
         rtc_rd_n  <= 1'b1;
         rtc_wr_n  <= 1'b1;
         rtc_ad_n  <= 1'b1;
         rtc_ad_o  <= 8'h00;
         rtc_ad_oe <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            stage[i]  <= 8'h00;
            shadow[i] <= 8'h00;
         end
`ifdef RTC_SEQ_VERIFY_EN
         vfy     <= 1'b0;
         rd_data <= 8'h00;
         wr_err  <= 1'b0;
`endif
      end else begin
         wr_ack <= 1'b0;
         sh_upd <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_req && (!want_rd || turn_wr)) begin
                  cyc_wr    <= 1'b1;
                  cyc_ref   <= 1'b0;
                  cyc_addr  <= wr_addr;
                  cyc_data  <= wr_data;
                  turn_wr   <= 1'b0;
                  state     <= A_SET;
                  ph_cnt    <= PH_LAST;
                  rtc_cs_n  <= 1'b0;
                  rtc_ad_oe <= 1'b1;
                  rtc_ad_o  <= wr_addr;
               end else if (want_rd) begin
                  // a pending tick becomes a sweep; it is consumed as the sweep starts
                  if (!sweeping) begin
                     sweeping <= 1'b1;
                     ref_pend <= 1'b0;
                  end
                  cyc_wr    <= 1'b0;
                  cyc_ref   <= 1'b1;
                  cyc_addr  <= sweep_addr;
                  turn_wr   <= 1'b1;
                  state     <= A_SET;
                  ph_cnt    <= PH_LAST;
                  rtc_cs_n  <= 1'b0;
                  rtc_ad_oe <= 1'b1;
                  rtc_ad_o  <= sweep_addr;
               end
            end
            A_SET: begin
               if (ph_done) begin
                  state    <= A_STB;
                  ph_cnt   <= PH_LAST;
                  rtc_ad_n <= 1'b0;
                  rtc_wr_n <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            A_STB: begin
               if (ph_done) begin
                  state    <= A_HLD;
                  ph_cnt   <= PH_LAST;
                  rtc_ad_n <= 1'b1;
                  rtc_wr_n <= 1'b1;
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            A_HLD: begin
               if (ph_done) begin
                  state  <= D_SET;
                  ph_cnt <= PH_LAST;
                  if (cyc_wr) begin
                     rtc_ad_o <= cyc_data;
                  end else begin
                     rtc_ad_oe <= 1'b0;
                     rtc_ad_o  <= 8'h00;
                  end
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            D_SET: begin
               if (ph_done) begin
                  state  <= D_STB;
                  ph_cnt <= PH_LAST;
                  if (cyc_wr) rtc_wr_n <= 1'b0;
                  else        rtc_rd_n <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            D_STB: begin
               if (ph_done) begin
                  state    <= D_HLD;
                  ph_cnt   <= PH_LAST;
                  rtc_wr_n <= 1'b1;
                  rtc_rd_n <= 1'b1;
                  if (cyc_ref) stage[sw_idx] <= rtc_ad_i;
`ifdef RTC_SEQ_VERIFY_EN
                  if (!cyc_wr) rd_data <= rtc_ad_i;
`endif
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            D_HLD: begin
               if (ph_done) begin
                  state     <= DONE;
                  rtc_cs_n  <= 1'b1;
                  rtc_ad_oe <= 1'b0;
                  rtc_ad_o  <= 8'h00;
                  // whole sweep lands in the shadow at once
                  if (cyc_ref && (sw_idx == IDX_LAST)) begin
                     for (int i = 0; i < 16; i++) shadow[i] <= stage[i];
                     sh_upd <= 1'b1;
                  end
`ifdef RTC_SEQ_VERIFY_EN
                  if (vfy) begin
                     wr_ack <= 1'b1;
                     wr_err <= (rd_data != cyc_data);
                  end
`else
                  if (cyc_wr) wr_ack <= 1'b1;
`endif
               end else begin
                  ph_cnt <= ph_cnt - 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               if (cyc_ref) begin
                  if (sw_idx == IDX_LAST) begin
                     sweeping <= 1'b0;
                     sw_idx   <= 4'd0;
                  end else begin
                     sw_idx <= sw_idx + 4'd1;
                  end
               end
`ifdef RTC_SEQ_VERIFY_EN
               // a write is chained straight into its read-back, bypassing arbitration
               if (cyc_wr) begin
                  cyc_wr    <= 1'b0;
                  vfy       <= 1'b1;
                  state     <= A_SET;
                  ph_cnt    <= PH_LAST;
                  rtc_cs_n  <= 1'b0;
                  rtc_ad_oe <= 1'b1;
                  rtc_ad_o  <= cyc_addr;
               end else begin
                  vfy <= 1'b0;
               end
`endif
            end
            default: state <= IDLE;
         endcase
         if (ref_tick) ref_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: write cycle timing, refresh sweep,
// write/sweep interleaving, merged ticks, mid-cycle reset and (with
// RTC_SEQ_VERIFY_EN) write read-back checking.
module tb_rtc_bus_sequencer;

   logic       CLK;
   logic       RESET;
   logic       wr_req;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       ref_tick;
   logic       busy;
   logic [3:0] sh_idx;
   logic [7:0] sh_val;
   logic       sh_upd;
   logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_n;
   logic [7:0] rtc_ad_o;
   logic       rtc_ad_oe;
   logic [7:0] rtc_ad_i;
`ifdef RTC_SEQ_VERIFY_EN
   logic       wr_err;
`endif

   int n_chk = 0;
   int n_err = 0;

   rtc_bus_sequencer dut (
      .CLK(CLK), .RESET(RESET),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .ref_tick(ref_tick), .busy(busy),
      .sh_idx(sh_idx), .sh_val(sh_val), .sh_upd(sh_upd),
      .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n), .rtc_ad_n(rtc_ad_n),
      .rtc_ad_o(rtc_ad_o), .rtc_ad_oe(rtc_ad_oe), .rtc_ad_i(rtc_ad_i)
`ifdef RTC_SEQ_VERIFY_EN
      , .wr_err(wr_err)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RTC model: latches the address strobe, returns addr+1 or echoes the
   // last written byte (corrupting 8'h59 into 8'h58)
   logic [7:0] bus_addr = 8'h00;
   logic [7:0] wdat     = 8'h00;
   logic       rtc_mode = 1'b0;
   always @(posedge CLK) begin
      if (!rtc_ad_n) bus_addr <= rtc_ad_o;
      if (!rtc_wr_n && rtc_ad_n && rtc_ad_oe) wdat <= rtc_ad_o;
   end
   assign rtc_ad_i = rtc_mode ? ((wdat == 8'h59) ? 8'h58 : wdat) : (bus_addr + 8'd1);

   // bus cycle log {is_write, addr} and pulse counters
   logic [8:0] log_q[$];
   logic prev_rd = 1'b1, prev_wr = 1'b1;
   int upd_cnt = 0;
   int ack_cnt = 0;
   always @(negedge CLK) begin
      if (!rtc_rd_n && prev_rd) log_q.push_back({1'b0, bus_addr});
      if (!rtc_wr_n && prev_wr && rtc_ad_n) log_q.push_back({1'b1, bus_addr});
      prev_rd = rtc_rd_n;
      prev_wr = rtc_wr_n;
      if (sh_upd) upd_cnt++;
      if (wr_ack) ack_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      repeat (3) tick();
      RESET = 1'b1;
      tick();
   endtask

   function automatic logic [8:0] log_at(input int i);
      if (i < log_q.size()) return log_q[i];
      return 9'h1FF;
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, output logic got_ack);
      got_ack = 1'b0;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wr_ack) begin
            got_ack = 1'b1;
            break;
         end
      end
      wr_req = 1'b0;
   endtask

   int cs_lo, busy_n, adn_first, adn_last, wrd_first, wrd_last, ack_at, ack_n;
   logic [7:0] ad_o5, ad_o17;
   int partial, len_at_upd, up0, ack0;
   logic seen, ok;

   initial begin
      RESET = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      ref_tick = 1'b0; sh_idx = 4'd0;
      repeat (3) tick();

      // reset state
      check("rst_strobes", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_n}, 4'hF);
      check("rst_oe_ado", {rtc_ad_oe, rtc_ad_o}, 9'h000);
      check("rst_ack_upd_busy", {wr_ack, sh_upd, busy}, 3'b000);
      check("rst_shadow", sh_val, 8'h00);
      RESET = 1'b1;
      tick();

      // single write cycle timing
      wr_addr = 8'h22; wr_data = 8'h59; wr_req = 1'b1;
      cs_lo = 0; busy_n = 0; adn_first = 0; adn_last = 0; wrd_first = 0; wrd_last = 0;
      ack_at = 0; ack_n = 0; ad_o5 = 8'h00; ad_o17 = 8'h00;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (!rtc_cs_n) cs_lo++;
         if (busy) busy_n++;
         if (!rtc_ad_n) begin
            if (adn_first == 0) adn_first = k;
            adn_last = k;
         end
         if (!rtc_wr_n && rtc_ad_n) begin
            if (wrd_first == 0) wrd_first = k;
            wrd_last = k;
         end
         if (k == 5) ad_o5 = rtc_ad_o;
         if (k == 17) ad_o17 = rtc_ad_o;
         if (wr_ack) begin
            ack_at = k;
            ack_n++;
            wr_req = 1'b0;
         end
      end
      check("wr_cs_low_cycles", cs_lo, 24);
      check("wr_adn_first", adn_first, 5);
      check("wr_adn_last", adn_last, 8);
      check("wr_addr_on_bus", ad_o5, 8'h22);
      check("wr_wrn_first", wrd_first, 17);
      check("wr_wrn_last", wrd_last, 20);
      check("wr_data_on_bus", ad_o17, 8'h59);
      check("wr_ack_cycle", ack_at, 25);
      check("wr_ack_count", ack_n, 1);
      check("wr_busy_cycles", busy_n, 25);

      // write and tick together, write held through the sweep
      do_reset();
      log_q.delete();
      up0 = upd_cnt;
      partial = 0; len_at_upd = 0; seen = 1'b0;
      sh_idx = 4'd0;
      wr_addr = 8'h40; wr_data = 8'h11; wr_req = 1'b1; ref_tick = 1'b1;
      tick();
      ref_tick = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (sh_upd) begin
            seen = 1'b1;
            len_at_upd = log_q.size();
            wr_req = 1'b0;
            break;
         end else if (sh_val != 8'h00) begin
            partial++;
         end
      end
      check("mix_upd_seen", seen, 1'b1);
      check("mix_no_partial", partial, 0);
      check("mix_log_len", len_at_upd, 18);
      check("mix_log0", log_at(0), 9'h140);
      check("mix_log1", log_at(1), 9'h021);
      check("mix_log2", log_at(2), 9'h140);
      check("mix_log3", log_at(3), 9'h022);
      check("mix_log17", log_at(17), 9'h029);
      repeat (40) tick();
      check("mix_upd_once", upd_cnt - up0, 1);
      check("mix_idle", busy, 1'b0);
      for (int i = 0; i < 9; i++) begin
         sh_idx = 4'(i);
         #1;
         check($sformatf("sh_val%0d", i), sh_val, 8'h22 + 8'(i));
      end
      sh_idx = 4'd12;
      #1;
      check("sh_val12", sh_val, 8'h00);
      sh_idx = 4'd0;

      // three ticks during one sweep give exactly one more sweep
      log_q.delete();
      up0 = upd_cnt;
      ref_tick = 1'b1;
      tick();
      ref_tick = 1'b0;
      repeat (30) tick();
      for (int j = 0; j < 3; j++) begin
         ref_tick = 1'b1;
         tick();
         ref_tick = 1'b0;
         repeat (40) tick();
      end
      repeat (700) tick();
      check("merge_upd_count", upd_cnt - up0, 2);
      check("merge_read_count", log_q.size(), 18);
      check("merge_idle", busy, 1'b0);

      // reset during the data strobe of a write
      ack0 = ack_cnt;
      wr_addr = 8'h50; wr_data = 8'h77; wr_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!rtc_wr_n && rtc_ad_n) begin
            seen = 1'b1;
            break;
         end
      end
      check("rstmid_reached_dstb", seen, 1'b1);
      RESET = 1'b0;
      wr_req = 1'b0;
      #1;
      check("rstmid_strobes", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_n}, 4'hF);
      check("rstmid_oe", rtc_ad_oe, 1'b0);
      repeat (2) tick();
      RESET = 1'b1;
      repeat (30) tick();
      check("rstmid_no_ack", ack_cnt - ack0, 0);
      check("rstmid_shadow0", sh_val, 8'h00);
      sh_idx = 4'd3;
      #1;
      check("rstmid_shadow3", sh_val, 8'h00);
      check("rstmid_idle", busy, 1'b0);

`ifdef RTC_SEQ_VERIFY_EN
      // read-back mismatch then match
      rtc_mode = 1'b1;
      do_write(8'h30, 8'h59, ok);
      check("vfy_ack1", ok, 1'b1);
      check("vfy_err_set", wr_err, 1'b1);
      repeat (3) tick();
      do_write(8'h31, 8'h5A, ok);
      check("vfy_ack2", ok, 1'b1);
      check("vfy_err_clr", wr_err, 1'b0);
      rtc_mode = 1'b0;
`else
      // a plain write after reset still acks
      do_write(8'h31, 8'h5A, ok);
      check("post_write_ack", ok, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
